// File: rtl/data_memory_sync.sv
// Word-organised data RAM with request/response handshake, programmable latency
// and byte/halfword/word loads and stores with sign or zero extension.
module data_memory_sync #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h7FFF_F000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    stateReg, stateNext;
    logic [3:0]    cntReg, cntNext;
    logic          accept, commit, reqErr;
    logic [31:0]   reqOffset;

    logic          wrReg, signedReg, errReg;
    logic [1:0]    sizeReg, laneReg;
    logic [AW-1:0] indexReg;
    logic [31:0]   wdataReg;

    logic          opWrite, opErr;
    logic [1:0]    opSize, opLane;
    logic [AW-1:0] opIndex;
    logic [31:0]   opWdata;

    logic          respErrReg, loadOkReg, extSignedReg;
    logic [1:0]    extSizeReg, extLaneReg;
    logic [31:0]   rawWord, shiftedWord, extWord;

    assign accept     = req_valid & req_ready;
    assign req_ready  = (stateReg != ST_WAIT);
    assign resp_valid = (stateReg == ST_RESP);

    // The unsigned difference also catches addresses below the base (wraps high).
    assign reqOffset = req_addr - BASE_ADDR;
    assign reqErr    = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                     | ({1'b0, reqOffset} >= SPAN);

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            ST_WAIT: begin
                if (cntReg == 4'd0) stateNext = ST_RESP;
                else                cntNext   = cntReg - 4'd1;
            end
            default: begin
                if (accept) begin
                    stateNext = (LATENCY > 1) ? ST_WAIT : ST_RESP;
                    cntNext   = CNT_INIT;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= ST_IDLE;
            cntReg    <= 4'd0;
            wrReg     <= 1'b0;
            sizeReg   <= 2'b00;
            signedReg <= 1'b0;
            laneReg   <= 2'b00;
            indexReg  <= '0;
            wdataReg  <= 32'd0;
            errReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                wrReg     <= req_write;
                sizeReg   <= req_size;
                signedReg <= req_signed;
                laneReg   <= req_addr[1:0];
                indexReg  <= reqOffset[AW+1:2];
                wdataReg  <= req_wdata;
                errReg    <= reqErr;
            end
        end
    end

    // With single-cycle latency the array is accessed on the accept edge itself,
    // so the live request fields feed the datapath instead of the latched copies.
    generate
        if (LATENCY == 1) begin : gDirect
            assign opWrite = req_write;
            assign opErr   = reqErr;
            assign opSize  = req_size;
            assign opLane  = req_addr[1:0];
            assign opIndex = reqOffset[AW+1:2];
            assign opWdata = req_wdata;
        end else begin : gLatched
            assign opWrite = wrReg;
            assign opErr   = errReg;
            assign opSize  = sizeReg;
            assign opLane  = laneReg;
            assign opIndex = indexReg;
            assign opWdata = wdataReg;
        end
    endgenerate

    assign commit = rst_n & (((stateReg == ST_WAIT) && (cntReg == 4'd0)) || ((LATENCY == 1) && accept));

    for (genvar gi = 0; gi < 4; gi++) begin : gLane
        logic [7:0] laneMem [DEPTH_WORDS];
        logic [7:0] rdByte;
        logic       laneWe;
        logic [7:0] laneWdata;

        always_comb begin
            laneWe = opWrite & ~opErr &
                     ((opSize == 2'b10) ||
                      ((opSize == 2'b01) && (opLane[1] == 1'(gi / 2))) ||
                      ((opSize == 2'b00) && (opLane == 2'(gi))));
            if (opSize == 2'b10)                      laneWdata = opWdata[8*gi +: 8];
            else if ((opSize == 2'b01) && (gi % 2 == 1)) laneWdata = opWdata[15:8];
            else                                      laneWdata = opWdata[7:0];
        end

        always_ff @(posedge clk) begin
            if (commit) begin
                if (laneWe) laneMem[opIndex] <= laneWdata;
                rdByte <= laneMem[opIndex];
            end
        end
    end

    assign rawWord = {gLane[3].rdByte, gLane[2].rdByte, gLane[1].rdByte, gLane[0].rdByte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respErrReg   <= 1'b0;
            loadOkReg    <= 1'b0;
            extSizeReg   <= 2'b00;
            extSignedReg <= 1'b0;
            extLaneReg   <= 2'b00;
        end else if (commit) begin
            respErrReg   <= opErr;
            loadOkReg    <= ~opWrite & ~opErr;
            extSizeReg   <= opSize;
            extSignedReg <= req_signed_sel();
            extLaneReg   <= opLane;
        end
    end

    function automatic logic req_signed_sel();
        return (LATENCY == 1) ? req_signed : signedReg;
    endfunction

    assign shiftedWord = rawWord >> {extLaneReg, 3'b000};

    always_comb begin
        case (extSizeReg)
            2'b00:   extWord = {{24{extSignedReg & shiftedWord[7]}}, shiftedWord[7:0]};
            2'b01:   extWord = {{16{extSignedReg & shiftedWord[15]}}, shiftedWord[15:0]};
            default: extWord = rawWord;
        endcase
    end

    assign resp_rdata = loadOkReg ? extWord : 32'd0;
    assign resp_error = respErrReg;
endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench: three instances (latency 2, 3 and 1) driven by directed vectors,
// responses checked by a monitor against a queue of expected data, error and due edge.
module tb_data_memory_sync;
    localparam int LAT [3] = '{2, 3, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid [3];
    logic        reqReady [3];
    logic        reqWrite [3];
    logic [1:0]  reqSize  [3];
    logic        reqSigned[3];
    logic [31:0] reqAddr  [3];
    logic [31:0] reqWdata [3];
    logic        respValid[3];
    logic [31:0] respRdata[3];
    logic        respError[3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : gDut
        data_memory_sync #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (32'h7FFF_F000),
            .LATENCY    (gi == 0 ? 2 : (gi == 1 ? 3 : 1))
        ) uDut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (reqValid[gi]),
            .req_ready (reqReady[gi]),
            .req_write (reqWrite[gi]),
            .req_size  (reqSize[gi]),
            .req_signed(reqSigned[gi]),
            .req_addr  (reqAddr[gi]),
            .req_wdata (reqWdata[gi]),
            .resp_valid(respValid[gi]),
            .resp_rdata(respRdata[gi]),
            .resp_error(respError[gi])
        );
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sbQ [3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    int   lastAcc [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request, holds it until accepted, and queues the expected response.
    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] expD, input logic expE, input bit push);
        bit   got;
        exp_t e;
        reqWrite[d]  = w;
        reqSize[d]   = sz;
        reqSigned[d] = sg;
        reqAddr[d]   = a;
        reqWdata[d]  = wd;
        reqValid[d]  = 1'b1;
        got = 1'b0;
        for (int w8 = 0; w8 < 64 && !got; w8++) begin
            @(negedge clk);
            got = reqReady[d];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: got req_ready=0 expected 1", d);
            reqValid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        lastAcc[d] = cyc;
        if (push) begin
            e.data = expD;
            e.err  = expE;
            e.due  = cyc + LAT[d];
            sbQ[d].push_back(e);
        end
    endtask

    task automatic st(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        issue(d, 1'b1, sz, 1'b0, a, wd, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic ld(input int d, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] expD);
        issue(d, 1'b0, sz, sg, a, 32'd0, expD, 1'b0, 1'b1);
    endtask

    task automatic er(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd);
        issue(d, w, sz, 1'b0, a, wd, 32'd0, 1'b1, 1'b1);
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 100 && !empty; k++) begin
            @(posedge clk);
            empty = (sbQ[0].size() == 0) && (sbQ[1].size() == 0) && (sbQ[2].size() == 0);
        end
        #1;
        if (!empty) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0",
                     sbQ[0].size(), sbQ[1].size(), sbQ[2].size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqSize[d] = 2'b00;
            reqSigned[d] = 1'b0; reqAddr[d] = 32'd0; reqWdata[d] = 32'd0;
        end
        fork
            begin : monitor
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    for (int d = 0; d < 3; d++) begin
                        if (respValid[d] === 1'b1) begin
                            if (sbQ[d].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0", d);
                            end else begin
                                e = sbQ[d].pop_front();
                                $display("txn dut%0d edge %0d rdata=%h err=%b (want %h %b due %0d)",
                                         d, cyc + 1, respRdata[d], respError[d], e.data, e.err, e.due);
                                chk("rdata", respRdata[d], e.data);
                                chk("error", 32'(respError[d]), 32'(e.err));
                                chk("timing", 32'(cyc + 1), 32'(e.due));
                            end
                        end
                    end
                end
            end
            begin : stimulus
                #2;
                for (int d = 0; d < 3; d++) begin
                    chk("reset_ready", 32'(reqReady[d]), 32'd1);
                    chk("reset_valid", 32'(respValid[d]), 32'd0);
                    chk("reset_rdata", respRdata[d], 32'd0);
                    chk("reset_error", 32'(respError[d]), 32'd0);
                end
                @(negedge clk) rst_n = 1'b1;
                @(posedge clk); #1;

                // Word round trip, then read-after-write on the same word
                st(0, 2'b10, 32'h7FFF_FFE0, 32'd5);
                ld(0, 2'b10, 1'b0, 32'h7FFF_FFE0, 32'h0000_0005);
                // Sub-word loads
                st(0, 2'b10, 32'h7FFF_FFF0, 32'hFFFF_3E79);
                ld(0, 2'b00, 1'b1, 32'h7FFF_FFF0, 32'h0000_0079);
                ld(0, 2'b00, 1'b1, 32'h7FFF_FFF1, 32'h0000_003E);
                ld(0, 2'b01, 1'b1, 32'h7FFF_FFF2, 32'hFFFF_FFFF);
                ld(0, 2'b01, 1'b0, 32'h7FFF_FFF2, 32'h0000_FFFF);
                ld(0, 2'b00, 1'b1, 32'h7FFF_FFF3, 32'hFFFF_FFFF);
                ld(0, 2'b00, 1'b0, 32'h7FFF_FFF3, 32'h0000_00FF);
                ld(0, 2'b01, 1'b0, 32'h7FFF_FFF0, 32'h0000_3E79);
                // Partial stores
                st(0, 2'b10, 32'h7FFF_FFA0, 32'd18);
                st(0, 2'b00, 32'h7FFF_FFA1, 32'h0000_00AB);
                st(0, 2'b01, 32'h7FFF_FFA2, 32'h0000_1234);
                ld(0, 2'b10, 1'b0, 32'h7FFF_FFA0, 32'h1234_AB12);
                // Errors and range boundaries
                er(0, 1'b0, 2'b10, 32'h7FFF_FFA2, 32'd0);
                er(0, 1'b0, 2'b10, 32'h0000_1000, 32'd0);
                er(0, 1'b0, 2'b11, 32'h7FFF_FFA0, 32'd0);
                er(0, 1'b1, 2'b11, 32'h7FFF_FFA0, 32'hDEAD_BEEF);
                er(0, 1'b1, 2'b10, 32'h7FFF_FFA1, 32'hDEAD_BEEF);
                er(0, 1'b1, 2'b01, 32'h7FFF_FFA3, 32'hDEAD_BEEF);
                ld(0, 2'b10, 1'b0, 32'h7FFF_FFA0, 32'h1234_AB12);
                er(0, 1'b0, 2'b10, 32'h8000_0000, 32'd0);
                er(0, 1'b0, 2'b10, 32'h7FFF_EFFC, 32'd0);
                st(0, 2'b10, 32'h7FFF_FFFC, 32'hCAFE_F00D);
                ld(0, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'hCAFE_F00D);
                reqValid[0] = 1'b0;
                drain();

                // Back-to-back at latency 3
                st(1, 2'b10, 32'h7FFF_F000, 32'h1122_3344);
                ld(1, 2'b10, 1'b0, 32'h7FFF_F000, 32'h1122_3344);
                lastAcc[0] = lastAcc[1];
                ld(1, 2'b00, 1'b0, 32'h7FFF_F001, 32'h0000_0033);
                chk("b2b_gap_lat3_a", 32'(lastAcc[1] - lastAcc[0]), 32'd3);
                lastAcc[0] = lastAcc[1];
                ld(1, 2'b01, 1'b1, 32'h7FFF_F002, 32'h0000_1122);
                chk("b2b_gap_lat3_b", 32'(lastAcc[1] - lastAcc[0]), 32'd3);
                reqValid[1] = 1'b0;
                drain();

                // Back-to-back at latency 1
                st(2, 2'b10, 32'h7FFF_F100, 32'hA5A5_5A5A);
                ld(2, 2'b00, 1'b0, 32'h7FFF_F100, 32'h0000_005A);
                lastAcc[0] = lastAcc[2];
                ld(2, 2'b00, 1'b1, 32'h7FFF_F102, 32'hFFFF_FFA5);
                chk("b2b_gap_lat1_a", 32'(lastAcc[2] - lastAcc[0]), 32'd1);
                lastAcc[0] = lastAcc[2];
                ld(2, 2'b01, 1'b0, 32'h7FFF_F102, 32'h0000_A5A5);
                chk("b2b_gap_lat1_b", 32'(lastAcc[2] - lastAcc[0]), 32'd1);
                ld(2, 2'b01, 1'b1, 32'h7FFF_F100, 32'h0000_5A5A);
                ld(2, 2'b10, 1'b0, 32'h7FFF_F100, 32'hA5A5_5A5A);
                reqValid[2] = 1'b0;
                drain();

                // Reset during WAIT drops the store
                ld(0, 2'b10, 1'b0, 32'h7FFF_FFE0, 32'h0000_0005);
                reqValid[0] = 1'b0;
                drain();
                @(posedge clk); #1;
                issue(0, 1'b1, 2'b10, 1'b0, 32'h7FFF_FFE0, 32'd7, 32'd0, 1'b0, 1'b0);
                reqValid[0] = 1'b0;
                #3 rst_n = 1'b0;
                #1;
                chk("midrst_ready", 32'(reqReady[0]), 32'd1);
                chk("midrst_valid", 32'(respValid[0]), 32'd0);
                chk("midrst_rdata", respRdata[0], 32'd0);
                chk("midrst_error", 32'(respError[0]), 32'd0);
                repeat (2) @(posedge clk);
                @(negedge clk) rst_n = 1'b1;
                #1;
                chk("postrst_ready", 32'(reqReady[0]), 32'd1);
                @(posedge clk); #1;
                ld(0, 2'b10, 1'b0, 32'h7FFF_FFE0, 32'h0000_0005);
                reqValid[0] = 1'b0;
                drain();
                repeat (3) @(posedge clk);
                done = 1'b1;
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
